// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial WIDTH-bit adder/subtractor, LSB first
//
// One full-adder/full-subtractor slice is reused for WIDTH cycles. The
// operand shadow registers shift right so the slice always sees bit 0.
// The result shifts in from the top, so after WIDTH steps it is aligned.
// Release of rst_n is assumed to be synchronised upstream.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             ov
);

  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic             c_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] result_q;
  logic             cb_q;
  logic             ov_q;
  logic             busy_q;
  logic             done_q;

  logic             sum_d;
  logic             carry_d;
  logic             ov_d;

  // Single slice: sum/difference bit, next carry/borrow, and the overflow
  // flag that is only captured on the MSB step (a_q[0]/b_q[0] are then the
  // original operand MSBs and sum_d is the result MSB).
  always_comb begin
    sum_d   = a_q[0] ^ b_q[0] ^ c_q;
    carry_d = 1'b0;
    ov_d    = 1'b0;
    if (mode_q) begin
      carry_d = (~a_q[0] & b_q[0]) | (c_q & ~(a_q[0] ^ b_q[0]));
      ov_d    = (a_q[0] != b_q[0]) & (sum_d != a_q[0]);
    end else begin
      carry_d = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
      ov_d    = (a_q[0] == b_q[0]) & (sum_d != a_q[0]);
    end
  end

  // Control FSM with registered outputs; operands latch only in IDLE/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      c_q      <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cb_q     <= 1'b0;
      ov_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode;
            c_q     <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          result_q <= {sum_d, result_q[WIDTH-1:1]};
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          c_q      <= carry_d;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cb_q    <= carry_d;
            ov_q    <= ov_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cb     = cb_q;
  assign ov     = ov_q;

endmodule
